debug_leds: RTL and testbench
=============================

# debug_leds

Wishbone peripheral (responder) driving on-board LEDs; the output-side counterpart to the button/switch controller that initiates Wishbone writes. A controller writes LED value, blink mask and brightness registers; the block acknowledges each access, returns register contents on reads and drives `leds` with blinking and optional PWM dimming applied.

## Interface
- `NUM_LEDS`, 8: LED count (1–8); register fields use bits `[NUM_LEDS-1:0]`, upper data bits write-ignored / read 0.
- `BLINK_PERIOD`, 5: clock cycles per blink half-period (hardware builds use 50_000_000); must be ≥ 1.
- `wb.clk_i`  input  1  sole clock (Wishbone interface clock).
- `wb.rst_i`  input  1  reset, asynchronous, active-high.
- `wb`  interface  —  `wishbone.peripheral` modport: `cyc_i`, `stb_i`, `we_i`, `adr_i`, `dat_i` (32), `dat_o` (32), `ack_o`.
- `leds`  output  NUM_LEDS  LED drive, registered.

## Operation
- Registers, decoded from `adr_i[1:0]`; reset values given:
  - 0 `LED_VALUE`: 0.
  - 1 `BLINK_MASK`: 0.
  - 2 `BRIGHTNESS` (8 bits): 8'hFF.
  - 3: reserved; reads 0, writes acked and ignored.
- Access accepted when `cyc_i && stb_i && !ack_o`. Next cycle: `ack_o`=1 for exactly one cycle; a write updates the register on that same edge; `dat_o` holds the read data while `ack_o`=1 and is 0 otherwise.
- Requests held across the ack cycle are not double-accepted; a new request is accepted on the cycle after `ack_o` falls. Maximum throughput is one access per 2 cycles.
- `stb_i` dropped before `ack_o`: no effect, because acceptance already happened on the first qualifying edge.
- Blink timer counts 0..`BLINK_PERIOD`-1. On wrap it toggles `blink_phase`, which resets to 0. The timer is free-running and unaffected by bus writes.
- Pixel logic: `lit = LED_VALUE & ~(BLINK_MASK & {NUM_LEDS{blink_phase}})`, then `leds <= lit & {NUM_LEDS{pwm_on}}`.
- Simultaneous write and blink/PWM wrap: both take effect on the same edge; `leds` reflects the new register one cycle later.
- Reset at any time, including mid-access: `ack_o`, `dat_o`, `leds`, the timers and `blink_phase` clear to 0 immediately; registers return to their reset values; any in-flight access is dropped without an ack.

## Timing
- Access latency: request edge N → `ack_o` at N+1 → `leds` updated at N+2.
- `leds` reset value 0; first non-zero output possible 2 cycles after the first write.
- Blink: `blink_phase` toggles every `BLINK_PERIOD` cycles; the first toggle is `BLINK_PERIOD` cycles after reset release.
- PWM: 8-bit free-running counter with period 256 cycles.
  - `pwm_on` = (`BRIGHTNESS`==8'hFF) || (`pwm_cnt` < `BRIGHTNESS`).
  - 0 gives always off; 255 gives always on.

## Configuration
- `DEBUG_LEDS_PWM_EN` defined: PWM counter and `BRIGHTNESS` register present as described.
- Not defined:
  - `pwm_on` tied to 1; no PWM counter exists.
  - Address 2 behaves as reserved: reads 0, writes acked and ignored.

## Structure
- `debug_leds_pkg` holds:
  - register index enum `LED_VALUE_ADDR`, `BLINK_MASK_ADDR`, `BRIGHTNESS_ADDR`;
  - reset-value constants;
  - `PWM_WIDTH` = 8.
- Sub-module `led_pwm`: PWM counter plus comparator; inputs clock, reset and `BRIGHTNESS`; output `pwm_on`. Instantiated only under `DEBUG_LEDS_PWM_EN`.
- The bus slave FSM (IDLE/ACK) and the blink timer live in the top module.

## Test plan
- Reset, then write 8'hA5 to address 0 → `ack_o` high exactly one cycle at N+1; `leds`=8'hA5 from N+2 (PWM at reset brightness 8'hFF).
- Write `LED_VALUE`=8'hFF, `BLINK_MASK`=8'h0F, `BLINK_PERIOD`=5 → `leds` alternates 8'hFF / 8'hF0 every 5 cycles.
- Read addresses 0–3 after writing 8'h3C, 8'h81, 8'h40 → `dat_o` = 8'h3C, 8'h81, 8'h40, 0 on the respective ack cycles; `dat_o`=0 outside ack.
- Hold `cyc_i`/`stb_i` high for 6 cycles with `we_i`=1 → exactly 3 acks; the register holds the last data.
- With PWM enabled, `BRIGHTNESS`=8'h40 and `LED_VALUE`=1 → `leds[0]` high for 64 of every 256 cycles; `BRIGHTNESS`=0 → always 0.
- Assert `wb.rst_i` in the cycle between request and ack → no ack; `leds`=0 and registers at reset values immediately; a subsequent access is handled normally.

Source files
------------

// File: rtl/debug_leds_pkg.sv
// Shared definitions for debug_leds: register map, reset values and bus FSM states.
package debug_leds_pkg;

  localparam int PWM_WIDTH = 8;

  typedef enum logic [1:0] {
    LED_VALUE_ADDR  = 2'd0,
    BLINK_MASK_ADDR = 2'd1,
    BRIGHTNESS_ADDR = 2'd2,
    RESERVED_ADDR   = 2'd3
  } reg_addr_e;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  localparam logic [7:0]           LED_VALUE_RST  = 8'h00;
  localparam logic [7:0]           BLINK_MASK_RST = 8'h00;
  localparam logic [PWM_WIDTH-1:0] BRIGHTNESS_RST = 8'hFF;

endpackage

// File: rtl/debug_leds_if.sv
// Wishbone bus bundle shared by the LED peripheral and whoever drives it.
// Handshake: an access is taken when cyc_i && stb_i && !ack_o; ack_o pulses for one
// cycle on the next clock, dat_o is valid only while ack_o is high and 0 otherwise.
interface wishbone;
  logic        clk_i;
  logic        rst_i;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [1:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport peripheral (
    input  clk_i, rst_i, cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o
  );

  modport controller (
    input  clk_i, rst_i, dat_o, ack_o,
    output cyc_i, stb_i, we_i, adr_i, dat_i
  );
endinterface

// File: rtl/debug_leds_pwm.sv
// led_pwm: free-running 8-bit PWM counter and brightness comparator.
// Only built when DEBUG_LEDS_PWM_EN is defined.
`ifdef DEBUG_LEDS_PWM_EN
module led_pwm
  import debug_leds_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PWM_WIDTH-1:0] brightness,
  output logic                 pwm_on
);

  logic [PWM_WIDTH-1:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Full scale is forced on so 8'hFF never shows the one-cycle gap of the compare.
  assign pwm_on = (brightness == '1) || (pwm_cnt < brightness);

endmodule
`endif

// File: rtl/debug_leds.sv
// debug_leds: Wishbone LED peripheral with blink mask and, when DEBUG_LEDS_PWM_EN
// is defined, a PWM brightness register at address 2.
module debug_leds
  import debug_leds_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int BLINK_PERIOD = 5
) (
  wishbone.peripheral         wb,
  output logic [NUM_LEDS-1:0] leds,
  output bus_state_e          bus_state
);

  localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);

  logic                clk;
  logic                rst;
  logic                accept;
  logic                wr_en;
  logic [31:0]         rd_data;
  logic [NUM_LEDS-1:0] led_value;
  logic [NUM_LEDS-1:0] blink_mask;
  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;
  logic                pwm_on;
  logic                unused_dat;

  assign clk        = wb.clk_i;
  assign rst        = wb.rst_i;
  assign accept     = wb.cyc_i && wb.stb_i && !wb.ack_o;
  assign wr_en      = accept && wb.we_i;
  assign unused_dat = ^wb.dat_i[31:NUM_LEDS];

`ifdef DEBUG_LEDS_PWM_EN
  logic [PWM_WIDTH-1:0] brightness;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      brightness <= BRIGHTNESS_RST;
    else if (wr_en && reg_addr_e'(wb.adr_i) == BRIGHTNESS_ADDR)
      brightness <= wb.dat_i[PWM_WIDTH-1:0];
  end

  led_pwm u_led_pwm (
    .clk        (clk),
    .rst        (rst),
    .brightness (brightness),
    .pwm_on     (pwm_on)
  );
`else
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    rd_data = '0;
    case (reg_addr_e'(wb.adr_i))
      LED_VALUE_ADDR:  rd_data[NUM_LEDS-1:0] = led_value;
      BLINK_MASK_ADDR: rd_data[NUM_LEDS-1:0] = blink_mask;
`ifdef DEBUG_LEDS_PWM_EN
      BRIGHTNESS_ADDR: rd_data[PWM_WIDTH-1:0] = brightness;
`endif
      default:         rd_data = '0;
    endcase
  end

  // Bus FSM: the write lands on the accepting edge, ack_o follows for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_state  <= BUS_IDLE;
      wb.ack_o   <= 1'b0;
      wb.dat_o   <= '0;
      led_value  <= LED_VALUE_RST[NUM_LEDS-1:0];
      blink_mask <= BLINK_MASK_RST[NUM_LEDS-1:0];
    end else begin
      case (bus_state)
        BUS_IDLE: begin
          if (accept) begin
            bus_state <= BUS_ACK;
            wb.ack_o  <= 1'b1;
            wb.dat_o  <= wb.we_i ? '0 : rd_data;
            if (wb.we_i) begin
              case (reg_addr_e'(wb.adr_i))
                LED_VALUE_ADDR:  led_value  <= wb.dat_i[NUM_LEDS-1:0];
                BLINK_MASK_ADDR: blink_mask <= wb.dat_i[NUM_LEDS-1:0];
                default: ;
              endcase
            end
          end
        end
        BUS_ACK: begin
          bus_state <= BUS_IDLE;
          wb.ack_o  <= 1'b0;
          wb.dat_o  <= '0;
        end
        default: begin
          bus_state <= BUS_IDLE;
          wb.ack_o  <= 1'b0;
          wb.dat_o  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) leds <= '0;
    else     leds <= (led_value & ~(blink_mask & {NUM_LEDS{blink_phase}})) & {NUM_LEDS{pwm_on}};
  end

endmodule

// File: tb/tb_debug_leds.sv
// Bench for debug_leds: randomized Wishbone traffic against a cycle-count based LED model.
module tb_debug_leds;
  import debug_leds_pkg::*;

  localparam int NUM_LEDS     = 8;
  localparam int BLINK_PERIOD = 5;
`ifdef DEBUG_LEDS_PWM_EN
  localparam bit PWM_EN = 1'b1;
`else
  localparam bit PWM_EN = 1'b0;
`endif

  wishbone wb();
  logic [NUM_LEDS-1:0] leds;
  bus_state_e          bus_state;

  debug_leds #(.NUM_LEDS(NUM_LEDS), .BLINK_PERIOD(BLINK_PERIOD)) dut (
    .wb        (wb),
    .leds      (leds),
    .bus_state (bus_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  initial wb.clk_i = 1'b0;
  always #5 wb.clk_i = ~wb.clk_i;

  // ---------------- reference model ----------------
  logic [7:0] m_led, m_mask, m_bright;
  int         edges;
  logic [7:0] exp_leds;

  task automatic model_reset();
    m_led = 8'h00; m_mask = 8'h00; m_bright = 8'hFF;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [31:0] d);
    case (a)
      2'd0: m_led  = d[7:0];
      2'd1: m_mask = d[7:0];
      2'd2: if (PWM_EN) m_bright = d[7:0];
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_led};
      2'd1:    return {24'h0, m_mask};
      2'd2:    return PWM_EN ? {24'h0, m_bright} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // e = clock edges since reset release; phase flips each BLINK_PERIOD, PWM period is 256.
  function automatic logic [7:0] model_leds(input int e);
    logic phase;
    logic on;
    phase = ((e / BLINK_PERIOD) % 2) == 1;
    on    = (m_bright == 8'hFF) || ((e % 256) < int'(m_bright));
    return (m_led & ~(m_mask & {8{phase}})) & {8{on}};
  endfunction

  always @(posedge wb.clk_i or posedge wb.rst_i) begin
    if (wb.rst_i) begin
      edges    <= 0;
      exp_leds <= 8'h00;
    end else begin
      exp_leds <= model_leds(edges);
      edges    <= edges + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0; wb.adr_i = 2'd0; wb.dat_i = 32'h0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge wb.clk_i);
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1; wb.adr_i = a; wb.dat_i = d;
    @(posedge wb.clk_i); #1;
    model_write(a, d);
    checks++;
    if (wb.ack_o !== 1'b1) begin
      errors++; $display("FAIL write_ack adr=%0d: got %b expected 1", a, wb.ack_o);
    end
    bus_idle();
    @(posedge wb.clk_i); #1;
    checks++;
    if (wb.ack_o !== 1'b0) begin
      errors++; $display("FAIL write_ack_drop adr=%0d: got %b expected 0", a, wb.ack_o);
    end
  endtask

  task automatic wb_read(input logic [1:0] a);
    logic [31:0] exp_d;
    @(negedge wb.clk_i);
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b0; wb.adr_i = a; wb.dat_i = $urandom;
    exp_d = model_read(a);
    @(posedge wb.clk_i); #1;
    checks++;
    if (wb.ack_o !== 1'b1 || wb.dat_o !== exp_d) begin
      errors++;
      $display("FAIL read_data adr=%0d: got ack=%b dat=%h expected ack=1 dat=%h", a, wb.ack_o, wb.dat_o, exp_d);
    end
    bus_idle();
    @(posedge wb.clk_i); #1;
    checks++;
    if (wb.ack_o !== 1'b0 || wb.dat_o !== 32'h0) begin
      errors++;
      $display("FAIL read_idle adr=%0d: got ack=%b dat=%h expected ack=0 dat=0", a, wb.ack_o, wb.dat_o);
    end
  endtask

  task automatic idle_check(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge wb.clk_i);
      checks++;
      if (leds !== exp_leds) begin
        errors++; $display("FAIL %s cycle %0d: leds got %h expected %h", name, i, leds, exp_leds);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge wb.clk_i);
    wb.rst_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if (wb.ack_o !== 1'b0 || wb.dat_o !== 32'h0 || leds !== 8'h00 || bus_state !== BUS_IDLE) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b dat=%h leds=%h state=%0d expected 0/0/0/0",
               wb.ack_o, wb.dat_o, leds, bus_state);
    end
    repeat (2) @(negedge wb.clk_i);
    wb.rst_i = 1'b0;
    idle_check(3, "reset_leds");
    for (int a = 0; a < 4; a++) wb_read(2'(a));
  endtask

  task automatic test_first_write();
    @(negedge wb.clk_i);
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1; wb.adr_i = 2'd0; wb.dat_i = 32'hA5;
    @(posedge wb.clk_i); #1;
    model_write(2'd0, 32'hA5);
    checks++;
    if (wb.ack_o !== 1'b1 || leds !== 8'h00) begin
      errors++; $display("FAIL first_ack: got ack=%b leds=%h expected ack=1 leds=00", wb.ack_o, leds);
    end
    bus_idle();
    @(posedge wb.clk_i); #1;
    checks++;
    if (wb.ack_o !== 1'b0 || leds !== 8'hA5) begin
      errors++; $display("FAIL first_leds: got ack=%b leds=%h expected ack=0 leds=a5", wb.ack_o, leds);
    end
    @(posedge wb.clk_i); #1;
    checks++;
    if (wb.ack_o !== 1'b0) begin
      errors++; $display("FAIL first_single_ack: got %b expected 0", wb.ack_o);
    end
  endtask

  task automatic test_blink();
    int seen_on;
    int seen_off;
    seen_on = 0; seen_off = 0;
    wb_write(2'd0, 32'hFF);
    wb_write(2'd1, 32'h0F);
    idle_check(1, "blink_settle");
    for (int i = 0; i < 30; i++) begin
      @(negedge wb.clk_i);
      checks++;
      if (leds !== exp_leds || (leds !== 8'hFF && leds !== 8'hF0)) begin
        errors++; $display("FAIL blink cycle %0d: leds got %h expected %h", i, leds, exp_leds);
      end
      if (leds === 8'hFF) seen_on++;
      if (leds === 8'hF0) seen_off++;
    end
    checks++;
    if (seen_on != 15 || seen_off != 15) begin
      errors++; $display("FAIL blink_balance: got %0d/%0d expected 15/15", seen_on, seen_off);
    end
  endtask

  task automatic test_readback();
    wb_write(2'd0, 32'h3C);
    wb_write(2'd1, 32'h81);
    wb_write(2'd2, 32'h40);
    for (int a = 0; a < 4; a++) wb_read(2'(a));
    idle_check(8, "readback_leds");
  endtask

  task automatic test_back_to_back();
    int acks;
    logic [31:0] d;
    acks = 0;
    @(negedge wb.clk_i);
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1; wb.adr_i = 2'd0;
    for (int i = 0; i < 6; i++) begin
      d = {$urandom_range(0, 255)} | 32'hFFFF_FF00;
      wb.dat_i = d;
      @(posedge wb.clk_i); #1;
      if (i % 2 == 0) model_write(2'd0, d);
      checks++;
      if (wb.ack_o !== (i % 2 == 0)) begin
        errors++; $display("FAIL hold_ack edge %0d: got %b expected %b", i, wb.ack_o, (i % 2 == 0));
      end
      if (wb.ack_o === 1'b1) acks++;
      @(negedge wb.clk_i);
    end
    bus_idle();
    checks++;
    if (acks != 3) begin
      errors++; $display("FAIL hold_ack_count: got %0d expected 3", acks);
    end
    wb_read(2'd0);
    idle_check(4, "hold_leds");
  endtask

`ifdef DEBUG_LEDS_PWM_EN
  task automatic test_pwm();
    int hi;
    wb_write(2'd1, 32'h00);
    wb_write(2'd0, 32'h01);
    wb_write(2'd2, 32'h40);
    idle_check(2, "pwm_settle");
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge wb.clk_i);
      if (leds[0] === 1'b1) hi++;
      checks++;
      if (leds !== exp_leds) begin
        errors++; $display("FAIL pwm40 cycle %0d: leds got %h expected %h", i, leds, exp_leds);
      end
    end
    checks++;
    if (hi != 64) begin
      errors++; $display("FAIL pwm40_duty: got %0d expected 64", hi);
    end
    wb_write(2'd2, 32'h00);
    idle_check(2, "pwm0_settle");
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge wb.clk_i);
      if (leds[0] !== 1'b0) hi++;
    end
    checks++;
    if (hi != 0) begin
      errors++; $display("FAIL pwm0_duty: got %0d expected 0", hi);
    end
    wb_write(2'd2, 32'hFF);
    idle_check(20, "pwm255");
  endtask
`else
  task automatic test_reserved_brightness();
    wb_write(2'd0, 32'h5A);
    wb_write(2'd2, 32'h12);
    wb_read(2'd2);
    idle_check(10, "no_pwm_leds");
  endtask
`endif

  task automatic test_random();
    logic [1:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 40; i++) begin
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) wb_write(a, d);
      else                           wb_read(a);
      idle_check($urandom_range(0, 3), "random_leds");
    end
  endtask

  task automatic test_reset_mid_access();
    wb_write(2'd2, 32'hFF);
    wb_write(2'd1, 32'h00);
    wb_write(2'd0, 32'hFF);
    idle_check(3, "pre_reset_leds");
    @(negedge wb.clk_i);
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1; wb.adr_i = 2'd1; wb.dat_i = 32'h55;
    #2;
    wb.rst_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if (leds !== 8'h00 || wb.ack_o !== 1'b0) begin
      errors++; $display("FAIL midreset_immediate: got leds=%h ack=%b expected 00/0", leds, wb.ack_o);
    end
    @(posedge wb.clk_i); #1;
    checks++;
    if (wb.ack_o !== 1'b0 || bus_state !== BUS_IDLE) begin
      errors++; $display("FAIL midreset_no_ack: got ack=%b state=%0d expected 0/0", wb.ack_o, bus_state);
    end
    @(negedge wb.clk_i);
    bus_idle();
    wb.rst_i = 1'b0;
    for (int a = 0; a < 3; a++) wb_read(2'(a));
    wb_write(2'd0, 32'h3C);
    idle_check(12, "post_reset_leds");
  endtask

  initial begin
    wb.rst_i = 1'b1;
    bus_idle();
    model_reset();
    test_reset();
    test_first_write();
    test_blink();
    test_readback();
    test_back_to_back();
`ifdef DEBUG_LEDS_PWM_EN
    test_pwm();
`else
    test_reserved_brightness();
`endif
    test_random();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
